instr_sequencer: RTL and testbench

//  Multi-cycle control FSM sitting directly upstream of the 16x16 register memory.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/seq_alu.sv | 39 +++
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_instr_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, instruction-field and FSM-state definitions for instr_sequencer and seq_alu.
// Optional feature macro: SEQ_MUL_EN (opcode 101 multiplies when defined, otherwise it is a NOP).
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int DST_MSB  = 12;
  localparam int DST_LSB  = 9;
  localparam int SRC1_MSB = 8;
  localparam int SRC1_LSB = 5;
  localparam int SRC2_MSB = 4;
  localparam int SRC2_LSB = 1;
  localparam int IMM5_MSB = 4;
  localparam int IMM9_MSB = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_CLEAR,
    S_RETIRE
  } state_e;

  function automatic logic signed [INSTR_W-1:0] sext5(input logic [4:0] v);
    return $signed({{(INSTR_W-5){v[4]}}, v});
  endfunction

  function automatic logic signed [INSTR_W-1:0] sext9(input logic [8:0] v);
    return $signed({{(INSTR_W-9){v[8]}}, v});
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: LOAD immediate, add/sub (register and immediate), DISPLAY pass-through.
// The 16x16 multiply (low half) exists only when SEQ_MUL_EN is defined.
module seq_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic        [2:0]        op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [8:0]        imm,
  output logic signed [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] imm5_s;
  logic signed [DATA_W-1:0] imm9_s;

  assign imm5_s = sext5(imm[IMM5_MSB:0]);
  assign imm9_s = sext9(imm[IMM9_MSB:0]);

  always_comb begin
    result = '0;
    case (op)
      OP_LOAD:    result = imm9_s;
      OP_ADD:     result = a + b;
      OP_ADDI:    result = a + imm5_s;
      OP_SUB:     result = a - b;
      OP_SUBI:    result = a - imm5_s;
`ifdef SEQ_MUL_EN
      OP_MUL:     result = a * b;
`else
      OP_MUL:     result = '0;
`endif
      OP_DISPLAY: result = a;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer driving a 16x16 register memory: handshake, decode, operand read, execute, write-back.
// Optional feature macro: SEQ_MUL_EN (opcode 101 multiplies; otherwise it retires as a NOP without touching registers).
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              rf_we,
  output logic [2:0]        rf_opcode,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [DATA_W-1:0]        instr_q;
  logic signed [DATA_W-1:0] res_q;
  logic [DATA_W-1:0]        result_q;
  logic signed [DATA_W-1:0] alu_y;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] dst_q, src1_q, src2_q;

  assign op_q   = instr_q[OP_MSB:OP_LSB];
  assign dst_q  = instr_q[DST_MSB:DST_LSB];
  assign src1_q = instr_q[SRC1_MSB:SRC1_LSB];
  assign src2_q = instr_q[SRC2_MSB:SRC2_LSB];

  seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      ($signed(rf_rdata1)),
    .b      ($signed(rf_rdata2)),
    .imm    (instr_q[IMM9_MSB:0]),
    .result (alu_y)
  );

  // Control state: FSM, read-latency counter and the visible result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_EXEC) result_q <= alu_y;
    end
  end

  // Datapath registers carry no reset; they are only consumed after being loaded.
  always_ff @(posedge clk) begin
    if (instr_valid && instr_ready) instr_q <= instr;
    if (state_q == S_EXEC)          res_q   <= alu_y;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    instr_ready  = 1'b0;
    rf_we        = 1'b0;
    rf_opcode    = 3'b000;
    rf_addr1     = '0;
    rf_addr2     = '0;
    rf_wdata     = '0;
    done         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        rf_addr1 = src1_q;
        rf_addr2 = src2_q;
        case (op_q)
          OP_LOAD:  state_d = S_EXEC;
          OP_CLEAR: state_d = S_CLEAR;
          OP_MUL: begin
`ifdef SEQ_MUL_EN
            state_d = S_READ;
            cnt_d   = CNT_INIT;
`else
            state_d = S_RETIRE;
`endif
          end
          default: begin
            state_d = S_READ;
            cnt_d   = CNT_INIT;
          end
        endcase
      end
      S_READ: begin
        rf_addr1 = src1_q;
        rf_addr2 = src2_q;
        if (cnt_q == 2'd0) state_d = S_EXEC;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_EXEC: begin
        // Operand addresses stay stable so the capture edge sees settled read data.
        rf_addr1 = src1_q;
        rf_addr2 = src2_q;
        state_d  = (op_q == OP_DISPLAY) ? S_RETIRE : S_WRITE;
      end
      S_WRITE: begin
        rf_we    = 1'b1;
        rf_addr1 = dst_q;
        rf_wdata = res_q;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_CLEAR: begin
        rf_opcode = OP_CLEAR;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      S_RETIRE: begin
        result_valid = (op_q == OP_DISPLAY);
        done         = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign result = result_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: runs every scenario on an RD_LAT=1 and an RD_LAT=3 instance.
// Honours SEQ_MUL_EN the same way as the design when modelling opcode 101.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tb_valid, sel, mem_clr;
  logic [15:0] tb_instr;
  int          n_checks, n_fail, cur_lat;
  logic [15:0] ref_regs [16];
  logic [15:0] exp_res;

  // Instance with RD_LAT=1
  logic        r1_ready, r1_we, r1_busy, r1_done, r1_rv;
  logic [2:0]  r1_opc;
  logic [3:0]  r1_a1, r1_a2;
  logic [15:0] r1_wd, r1_res, r1_rd1, r1_rd2;
  logic [15:0] mem1 [16];
  logic [15:0] pa1, pb1;

  // Instance with RD_LAT=3
  logic        r3_ready, r3_we, r3_busy, r3_done, r3_rv;
  logic [2:0]  r3_opc;
  logic [3:0]  r3_a1, r3_a2;
  logic [15:0] r3_wd, r3_res, r3_rd1, r3_rd2;
  logic [15:0] mem3 [16];
  logic [15:0] pa3_0, pa3_1, pa3_2, pb3_0, pb3_1, pb3_2;

  instr_sequencer #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .instr_valid(tb_valid & ~sel), .instr_ready(r1_ready), .instr(tb_instr),
    .rf_we(r1_we), .rf_opcode(r1_opc), .rf_addr1(r1_a1), .rf_addr2(r1_a2), .rf_wdata(r1_wd),
    .rf_rdata1(r1_rd1), .rf_rdata2(r1_rd2), .busy(r1_busy), .done(r1_done),
    .result(r1_res), .result_valid(r1_rv)
  );

  instr_sequencer #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .instr_valid(tb_valid & sel), .instr_ready(r3_ready), .instr(tb_instr),
    .rf_we(r3_we), .rf_opcode(r3_opc), .rf_addr1(r3_a1), .rf_addr2(r3_a2), .rf_wdata(r3_wd),
    .rf_rdata1(r3_rd1), .rf_rdata2(r3_rd2), .busy(r3_busy), .done(r3_done),
    .result(r3_res), .result_valid(r3_rv)
  );

  // Register memories with the matching read latency
  always @(posedge clk) begin
    if (mem_clr || r1_opc == 3'b110) begin
      for (int i = 0; i < 16; i++) mem1[i] <= '0;
    end else if (r1_we) mem1[r1_a1] <= r1_wd;
    pa1 <= mem1[r1_a1];
    pb1 <= mem1[r1_a2];
  end
  assign r1_rd1 = pa1;
  assign r1_rd2 = pb1;

  always @(posedge clk) begin
    if (mem_clr || r3_opc == 3'b110) begin
      for (int i = 0; i < 16; i++) mem3[i] <= '0;
    end else if (r3_we) mem3[r3_a1] <= r3_wd;
    pa3_0 <= mem3[r3_a1]; pa3_1 <= pa3_0; pa3_2 <= pa3_1;
    pb3_0 <= mem3[r3_a2]; pb3_1 <= pb3_0; pb3_2 <= pb3_1;
  end
  assign r3_rd1 = pa3_2;
  assign r3_rd2 = pb3_2;

  // Observed outputs of the instance under test
  logic        o_ready, o_we, o_busy, o_done, o_rv;
  logic [2:0]  o_opc;
  logic [3:0]  o_a1, o_a2;
  logic [15:0] o_wd, o_res;
  logic [47:0] snap;
  assign o_ready = sel ? r3_ready : r1_ready;
  assign o_we    = sel ? r3_we    : r1_we;
  assign o_busy  = sel ? r3_busy  : r1_busy;
  assign o_done  = sel ? r3_done  : r1_done;
  assign o_rv    = sel ? r3_rv    : r1_rv;
  assign o_opc   = sel ? r3_opc   : r1_opc;
  assign o_a1    = sel ? r3_a1    : r1_a1;
  assign o_a2    = sel ? r3_a2    : r1_a2;
  assign o_wd    = sel ? r3_wd    : r1_wd;
  assign o_res   = sel ? r3_res   : r1_res;
  assign snap    = {o_ready, o_busy, o_done, o_rv, o_we, o_opc, o_a1, o_a2, o_wd, o_res};
  localparam logic [47:0] RESET_SNAP = {1'b1, 47'b0};

  function automatic logic [15:0] enc_r(input int op, input int d, input int s1, input int s2);
    return {3'(op), 4'(d), 4'(s1), 4'(s2), 1'b0};
  endfunction
  function automatic logic [15:0] enc_i5(input int op, input int d, input int s1, input int imm);
    return {3'(op), 4'(d), 4'(s1), 5'(imm)};
  endfunction
  function automatic logic [15:0] enc_i9(input int d, input int imm);
    return {3'b000, 4'(d), 9'(imm)};
  endfunction

  task automatic run_instr(input logic [15:0] ins);
    logic [2:0]  op;
    logic [3:0]  d;
    logic [15:0] a, b, i5, i9, val, d_wd, d_res;
    logic [3:0]  d_a1;
    logic        d_we, d_rv;
    bit          wr, disp, clr, seen;
    int          lat, cyc, nclr, nwe_bad, n;
    op = ins[15:13]; d = ins[12:9];
    a = ref_regs[ins[8:5]]; b = ref_regs[ins[4:1]];
    i5 = {{11{ins[4]}}, ins[4:0]}; i9 = {{7{ins[8]}}, ins[8:0]};
    wr = 1; disp = 0; clr = 0; lat = 3 + cur_lat; val = '0;
    case (op)
      3'd0: begin val = i9; lat = 3; end
      3'd1: val = a + b;
      3'd2: val = a + i5;
      3'd3: val = a - b;
      3'd4: val = a - i5;
      3'd5: begin
`ifdef SEQ_MUL_EN
        val = a * b;
`else
        wr = 0; lat = 2;
`endif
      end
      3'd6: begin wr = 0; clr = 1; lat = 2; end
      default: begin wr = 0; disp = 1; val = a; end
    endcase
    tb_instr = ins; tb_valid = 1'b1; n = 0;
    while (!o_ready && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 40) begin n_fail++; $display("FAIL ready_wait ins=%h: ready never rose, required 1", ins); end
    @(negedge clk);
    tb_valid = 1'b0;
    cyc = 1; seen = 0; nclr = 0; nwe_bad = 0;
    d_we = 0; d_a1 = '0; d_wd = '0; d_res = '0; d_rv = 0;
    while (!seen && cyc <= 20) begin
      if (o_opc == 3'b110) nclr++;
      if (o_done) begin
        seen = 1; d_we = o_we; d_a1 = o_a1; d_wd = o_wd; d_res = o_res; d_rv = o_rv;
      end else begin
        if (o_we) nwe_bad++;
        @(negedge clk); cyc++;
      end
    end
    if (wr) ref_regs[d] = val;
    if (clr) for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    if (wr || disp) exp_res = val;
    n_checks++;
    if (cyc !== lat) begin n_fail++; $display("FAIL latency ins=%h: done at cycle %0d, required %0d", ins, cyc, lat); end
    n_checks++;
    if (d_we !== wr) begin n_fail++; $display("FAIL write_en ins=%h: rf_we=%b at done, required %b", ins, d_we, wr); end
    if (wr) begin
      n_checks++;
      if ({d_a1, d_wd} !== {d, val}) begin
        n_fail++; $display("FAIL write_data ins=%h: addr1=%h wdata=%h, required addr1=%h wdata=%h", ins, d_a1, d_wd, d, val);
      end
    end
    n_checks++;
    if (nclr !== int'(clr)) begin n_fail++; $display("FAIL clear_pulse ins=%h: %0d clear cycles, required %0d", ins, nclr, clr); end
    n_checks++;
    if (nwe_bad !== 0) begin n_fail++; $display("FAIL stray_we ins=%h: %0d rf_we cycles outside WRITE, required 0", ins, nwe_bad); end
    n_checks++;
    if ({d_rv, d_res} !== {disp, exp_res}) begin
      n_fail++; $display("FAIL result ins=%h: result_valid=%b result=%h, required %b %h", ins, d_rv, d_res, disp, exp_res);
    end
    @(negedge clk);
    n_checks++;
    if ({o_ready, o_busy} !== 2'b10) begin n_fail++; $display("FAIL ready_after ins=%h: ready/busy=%b, required 10", ins, {o_ready, o_busy}); end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1; tb_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (snap !== RESET_SNAP) begin n_fail++; $display("FAIL reset_hold: outputs=%h, required %h", snap, RESET_SNAP); end
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (snap !== RESET_SNAP) begin n_fail++; $display("FAIL reset_release: outputs=%h, required %h", snap, RESET_SNAP); end
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    exp_res = '0;
  endtask

  task automatic test_load();
    run_instr(enc_i9(2, 5));
  endtask

  task automatic test_alu_wrap();
    run_instr(enc_i9(1, -1));
    run_instr(enc_i9(2, 1));
    run_instr(enc_r(1, 3, 1, 2));
    run_instr(enc_i5(4, 4, 3, 1));
    run_instr(enc_i5(2, 7, 4, -16));
    run_instr(enc_r(3, 8, 2, 1));
    run_instr(enc_r(1, 2, 2, 2));
  endtask

  task automatic test_clear();
    run_instr(16'hC000);
    run_instr(enc_r(7, 0, 5, 0));
    run_instr(enc_r(7, 0, 1, 0));
  endtask

  task automatic test_reset_mid();
    int bad;
    run_instr(enc_i9(1, -1));
    run_instr(enc_i9(2, 1));
    run_instr(enc_i9(3, 9));
    tb_instr = enc_r(1, 3, 1, 2); tb_valid = 1'b1;
    @(negedge clk);
    tb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; bad = 0;
    @(negedge clk);
    n_checks++;
    if (snap !== RESET_SNAP) begin n_fail++; $display("FAIL reset_mid_state: outputs=%h, required %h", snap, RESET_SNAP); end
    repeat (3) begin
      if (o_we || o_opc == 3'b110) bad++;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_mid_effects: %0d write/clear cycles, required 0", bad); end
    exp_res = '0;
    run_instr(enc_r(7, 0, 3, 0));
  endtask

  task automatic test_mul();
    run_instr(enc_i9(1, 128));
    run_instr(enc_r(1, 1, 1, 1));
    run_instr(enc_i9(2, 128));
    run_instr(enc_r(1, 2, 2, 2));
    run_instr(enc_i9(6, 7));
    run_instr(enc_r(5, 6, 1, 2));
    run_instr(enc_r(7, 0, 6, 0));
    run_instr(enc_i9(4, -3));
    run_instr(enc_i9(5, 100));
    run_instr(enc_r(5, 9, 4, 5));
  endtask

  task automatic test_back_to_back();
    int acc, dn, first_dn, second_dn, lat;
    lat = 3 + cur_lat; acc = 0; dn = 0; first_dn = -1; second_dn = -1;
    tb_instr = enc_r(7, 0, 3, 0); tb_valid = 1'b1;
    for (int c = 0; c <= 2 * lat + 1; c++) begin
      if (o_ready && tb_valid) acc++;
      if (o_done) begin
        dn++;
        if (first_dn < 0) first_dn = c; else second_dn = c;
      end
      if (c == 2 * lat + 1) tb_valid = 1'b0;
      @(negedge clk);
    end
    exp_res = ref_regs[3];
    n_checks++;
    if (acc !== 2) begin n_fail++; $display("FAIL b2b_accepts: %0d transfers, required 2", acc); end
    n_checks++;
    if ({first_dn, second_dn} !== {lat, 2 * lat + 1}) begin
      n_fail++; $display("FAIL b2b_done_cycles: done at %0d,%0d, required %0d,%0d", first_dn, second_dn, lat, 2 * lat + 1);
    end
    n_checks++;
    if ({o_res, dn} !== {exp_res, 2}) begin
      n_fail++; $display("FAIL b2b_result: result=%h dones=%0d, required %h 2", o_res, dn, exp_res);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins, m;
    for (int k = 0; k < 40; k++) begin
      ins = 16'($urandom);
      if (ins[15:13] == 3'b110 && $urandom_range(0, 3) != 0) ins[15:13] = 3'b111;
      run_instr(ins);
    end
    for (int i = 0; i < 16; i++) begin
      m = sel ? mem3[i] : mem1[i];
      n_checks++;
      if (m !== ref_regs[i]) begin n_fail++; $display("FAIL regfile r%0d: holds %h, required %h", i, m, ref_regs[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; tb_valid = 1'b0; tb_instr = '0; sel = 1'b0; mem_clr = 1'b1;
    n_checks = 0; n_fail = 0; cur_lat = 1; exp_res = '0;
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 1);
      cur_lat = (pass == 1) ? 3 : 1;
      test_reset();
      test_load();
      test_alu_wrap();
      test_clear();
      test_reset_mid();
      test_mul();
      test_back_to_back();
      test_random();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
